// File: rtl/rename_pkg.sv
// rename_pkg: constants and types shared by the rename stage (free list and
// map table).
//   NumPhysRegs / NumArchRegs : register-file sizes
//   PhysRegWidth / phys_reg_t : physical register tag
//   free_list_state_e         : free-list init/run FSM states
package rename_pkg;
  localparam int NumPhysRegs  = 64;
  localparam int NumArchRegs  = 32;
  localparam int PhysRegWidth = $clog2(NumPhysRegs);

  typedef logic [PhysRegWidth-1:0] phys_reg_t;

  typedef enum logic {
    StInit,
    StRun
  } free_list_state_e;
endpackage

// File: rtl/free_list_ckpt_stack.sv
// free_list_ckpt_stack: NumCkpt-deep LIFO of free-list head pointers.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the stack)
//   push_i       : push data_i (dropped when full or when popping)
//   pop_i        : pop the top entry (dropped when empty)
//   data_i       : pointer to push
//   top_o        : current top entry (meaningless while empty_o)
//   full_o       : stack holds NumCkpt entries
//   empty_o      : stack holds no entries
module free_list_ckpt_stack #(
  parameter int NumCkpt = 4,
  parameter int PtrW    = 6,
  localparam int SW     = $clog2(NumCkpt + 1),
  localparam int IW     = $clog2(NumCkpt)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PtrW-1:0] data_i,
  output logic [PtrW-1:0] top_o,
  output logic            full_o,
  output logic            empty_o
);
  logic [PtrW-1:0] r_stk [NumCkpt];
  logic [SW-1:0]   r_sp;
  logic            w_push, w_pop;
  logic [IW-1:0]   w_wr_idx, w_top_idx;

  assign empty_o   = (r_sp == '0);
  assign full_o    = (r_sp == SW'(NumCkpt));
  // Pop has priority; a simultaneous push is discarded.
  assign w_pop     = pop_i & ~empty_o;
  assign w_push    = push_i & ~pop_i & ~full_o;
  assign w_wr_idx  = IW'(r_sp);
  assign w_top_idx = IW'(r_sp - SW'(1));
  assign top_o     = r_stk[w_top_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sp <= '0;
      for (int i = 0; i < NumCkpt; i++) r_stk[i] <= '0;
    end else if (w_pop) begin
      r_sp <= r_sp - SW'(1);
    end else if (w_push) begin
      r_stk[w_wr_idx] <= data_i;
      r_sp            <= r_sp + SW'(1);
    end
  end
endmodule

// File: rtl/free_list.sv
// free_list: physical-register free list for the 2-wide rename stage.
// A circular buffer of NumPhysRegs-NumArchRegs free tags; allocation pops up
// to two tags at head, commit pushes up to two retired tags at tail, and a
// LIFO of head checkpoints supports branch recovery.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   alloc_valid_i          : rename group presented
//   need_0_i / need_1_i    : instruction 0/1 needs a destination
//   alloc_ready_o          : whole group can be granted this cycle
//   phys_rd_0_o/_1_o       : tags for instruction 0/1 (combinational)
//   rel_0_i/rel_reg_0_i    : commit slot 0 frees a tag
//   rel_1_i/rel_reg_1_i    : commit slot 1 frees a tag
//   save_i / restore_i     : push / pop-and-restore a head checkpoint
//   ckpt_full_o            : checkpoint stack full
//   init_done_o            : buffer initialised, list operational
// Build option FREE_LIST_PERF_EN adds free_cnt_o (current free count) and
// stall_cnt_o (saturating count of stalled allocation cycles).
module free_list #(
  parameter int NumPhysRegs = rename_pkg::NumPhysRegs,
  parameter int NumArchRegs = rename_pkg::NumArchRegs,
  parameter int NumCkpt     = 4,
  localparam int PW         = $clog2(NumPhysRegs),
  localparam int DW         = $clog2(NumPhysRegs - NumArchRegs)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          alloc_valid_i,
  input  logic          need_0_i,
  input  logic          need_1_i,
  output logic          alloc_ready_o,
  output logic [PW-1:0] phys_rd_0_o,
  output logic [PW-1:0] phys_rd_1_o,
  input  logic          rel_0_i,
  input  logic [PW-1:0] rel_reg_0_i,
  input  logic          rel_1_i,
  input  logic [PW-1:0] rel_reg_1_i,
  input  logic          save_i,
  input  logic          restore_i,
  output logic          ckpt_full_o,
  output logic          init_done_o
`ifdef FREE_LIST_PERF_EN
  ,
  output logic [DW:0]   free_cnt_o,
  output logic [31:0]   stall_cnt_o
`endif
);
  import rename_pkg::*;

  localparam int Depth = NumPhysRegs - NumArchRegs;

  free_list_state_e r_state, w_state_nxt;
  logic [PW-1:0] r_mem [Depth];
  logic [DW:0]   r_head, r_tail;
  logic [DW-1:0] r_init_idx;

  logic          w_run, w_init_last, w_ready, w_fire;
  logic          w_restore, w_push, w_ckpt_empty;
  logic [DW:0]   w_count, w_n, w_head_alloc, w_head_nxt, w_top;
  logic [DW:0]   w_rel1_ptr, w_rel_cnt;
  logic [DW-1:0] w_head_idx, w_head1_idx;

  assign w_run       = (r_state == StRun);
  assign w_init_last = (r_init_idx == DW'(Depth - 1));
  // Pointers carry a wrap bit, so count spans 0..Depth without ambiguity.
  assign w_count     = r_tail - r_head;
  assign w_n         = (DW+1)'(need_0_i) + (DW+1)'(need_1_i);
  assign w_ready     = w_run & ~restore_i & (w_count >= w_n);
  assign w_fire      = alloc_valid_i & w_ready;
  assign w_head_alloc = w_fire ? r_head + w_n : r_head;
  assign w_restore   = w_run & restore_i & ~w_ckpt_empty;
  // A checkpoint records head after this cycle's allocation.
  assign w_push      = w_run & save_i & ~restore_i;
  assign w_head_nxt  = w_restore ? w_top : w_head_alloc;
  // Slot 1 takes the slot after slot 0 only when slot 0 also releases.
  assign w_rel1_ptr  = rel_0_i ? r_tail + (DW+1)'(1) : r_tail;
  assign w_rel_cnt   = (DW+1)'(rel_0_i) + (DW+1)'(rel_1_i);
  assign w_head_idx  = r_head[DW-1:0];
  assign w_head1_idx = w_head_idx + DW'(1);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StInit;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StInit:  if (w_init_last) w_state_nxt = StRun;
      StRun:   w_state_nxt = StRun;
      default: w_state_nxt = StInit;
    endcase
  end

  // FSM: outputs (tags are zero until the buffer is initialised)
  always_comb begin
    init_done_o   = w_run;
    alloc_ready_o = w_ready;
    phys_rd_0_o   = '0;
    phys_rd_1_o   = '0;
    if (w_run) begin
      phys_rd_0_o = r_mem[w_head_idx];
      phys_rd_1_o = need_0_i ? r_mem[w_head1_idx] : r_mem[w_head_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_init_idx <= '0;
    end else if (r_state == StInit) begin
      r_init_idx <= r_init_idx + DW'(1);
      if (w_init_last) r_tail <= (DW+1)'(Depth);
    end else begin
      r_head <= w_head_nxt;
      r_tail <= r_tail + w_rel_cnt;
    end
  end

  // Tag storage has no reset; outputs are gated until init has rewritten it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == StInit) begin
        r_mem[r_init_idx] <= PW'(NumArchRegs) + PW'(r_init_idx);
      end else begin
        if (rel_0_i) r_mem[r_tail[DW-1:0]]     <= rel_reg_0_i;
        if (rel_1_i) r_mem[w_rel1_ptr[DW-1:0]] <= rel_reg_1_i;
      end
    end
  end

  // More free tags than slots means a tag was released twice.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_run) assert (w_count <= (DW+1)'(Depth));
  end

  free_list_ckpt_stack #(
    .NumCkpt (NumCkpt),
    .PtrW    (DW + 1)
  ) u_ckpt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_restore),
    .data_i  (w_head_alloc),
    .top_o   (w_top),
    .full_o  (ckpt_full_o),
    .empty_o (w_ckpt_empty)
  );

`ifdef FREE_LIST_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_stall_cnt <= '0;
    else if (w_run && alloc_valid_i && !w_ready && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign free_cnt_o  = w_count;
  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
  localparam int PW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          alloc_valid_i = 1'b0, need_0_i = 1'b0, need_1_i = 1'b0;
  logic          rel_0_i = 1'b0, rel_1_i = 1'b0, save_i = 1'b0, restore_i = 1'b0;
  logic [PW-1:0] rel_reg_0_i = '0, rel_reg_1_i = '0;
  logic          alloc_ready_o, ckpt_full_o, init_done_o;
  logic [PW-1:0] phys_rd_0_o, phys_rd_1_o;
`ifdef FREE_LIST_PERF_EN
  logic [5:0]    free_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  free_list dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .alloc_valid_i (alloc_valid_i),
    .need_0_i      (need_0_i),
    .need_1_i      (need_1_i),
    .alloc_ready_o (alloc_ready_o),
    .phys_rd_0_o   (phys_rd_0_o),
    .phys_rd_1_o   (phys_rd_1_o),
    .rel_0_i       (rel_0_i),
    .rel_reg_0_i   (rel_reg_0_i),
    .rel_1_i       (rel_1_i),
    .rel_reg_1_i   (rel_reg_1_i),
    .save_i        (save_i),
    .restore_i     (restore_i),
    .ckpt_full_o   (ckpt_full_o),
    .init_done_o   (init_done_o)
`ifdef FREE_LIST_PERF_EN
    ,
    .free_cnt_o    (free_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  typedef struct {
    int id;
    bit rdy;
    bit n0;
    bit n1;
    int rd0;
    int rd1;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, aid = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every presented rename group consumes one scoreboard entry.
  always @(negedge clk) begin
    if (alloc_valid_i) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: group presented with no expectation queued");
      end else begin
        mon_e = expq.pop_front();
        chk($sformatf("alloc%0d_ready", mon_e.id), alloc_ready_o, mon_e.rdy);
        if (mon_e.rdy && mon_e.n0) chk($sformatf("alloc%0d_rd0", mon_e.id), phys_rd_0_o, mon_e.rd0);
        if (mon_e.rdy && mon_e.n1) chk($sformatf("alloc%0d_rd1", mon_e.id), phys_rd_1_o, mon_e.rd1);
      end
    end
  end

  // One cycle of stimulus, driven just after the edge and released after the next.
  task automatic cyc(input bit av, n0, n1, r0, input int rr0, input bit r1, input int rr1,
                     input bit sv, rs, erdy, input int e0, e1);
    alloc_valid_i = av; need_0_i = n0; need_1_i = n1;
    rel_0_i = r0; rel_reg_0_i = PW'(rr0); rel_1_i = r1; rel_reg_1_i = PW'(rr1);
    save_i = sv; restore_i = rs;
    if (av) begin
      aid++;
      expq.push_back(exp_t'{aid, erdy, n0, n1, e0, e1});
    end
    @(posedge clk); #1;
    alloc_valid_i = 0; need_0_i = 0; need_1_i = 0;
    rel_0_i = 0; rel_1_i = 0; save_i = 0; restore_i = 0;
  endtask

  task automatic alloc(input bit n0, n1, erdy, input int e0, e1);
    cyc(1, n0, n1, 0, 0, 0, 0, 0, 0, erdy, e0, e1);
  endtask

  task automatic sv();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic rs();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    rst_i = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_init_done", init_done_o, 0);
    chk("rst_alloc_ready", alloc_ready_o, 0);
    chk("rst_ckpt_full", ckpt_full_o, 0);
    chk("rst_rd0", phys_rd_0_o, 0);
    chk("rst_rd1", phys_rd_1_o, 0);
    rst_i = 0;
    while (!init_done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_latency", n, 32);
    need_0_i = 1; #1;
    chk("init_rd0", phys_rd_0_o, 32);
    chk("init_rd1", phys_rd_1_o, 33);
    need_0_i = 0;
  endtask

  int freeq[$];
  int inuse[$];

  initial begin
    bit av, n0, n1, r0, r1, rdy;
    int rr0, rr1, k, n, e0, e1;

    #1;
    do_reset();

    // Drain all 32 free tags, then both full and half groups must stall.
    for (int g = 0; g < 16; g++) alloc(1, 1, 1, 32 + 2*g, 33 + 2*g);
    alloc(1, 1, 0, 0, 0);
    alloc(1, 0, 0, 0, 0);
    alloc(0, 0, 1, 0, 0);            // empty group still fires

    // Release 5 and 7 while empty; not allocatable in the same cycle.
    cyc(1, 1, 1, 1, 5, 1, 7, 0, 0, 0, 0, 0);
    alloc(1, 1, 1, 5, 7);
    alloc(0, 1, 0, 0, 0);

    // Checkpoint and restore.
    do_reset();
    alloc(1, 1, 1, 32, 33);          // head = 2
    sv();
    alloc(1, 1, 1, 34, 35);
    alloc(1, 1, 1, 36, 37);
    alloc(1, 1, 1, 38, 39);          // head = 8
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    alloc(1, 1, 1, 34, 35);          // back at head = 2, now 4

    // Stack boundaries.
    sv();                            // push 4
    chk("ckpt_not_full", ckpt_full_o, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 36, 37); // push head after alloc = 6
    sv();
    sv();
    chk("ckpt_full", ckpt_full_o, 1);
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 38, 39); // save ignored, head = 8
    chk("ckpt_full_held", ckpt_full_o, 1);
    rs();
    chk("restore1_rd0", phys_rd_0_o, 38);
    chk("restore1_not_full", ckpt_full_o, 0);
    rs();
    rs();
    rs();
    chk("restore4_rd0", phys_rd_0_o, 36);
    rs();                            // empty stack: ignored
    chk("restore5_rd0", phys_rd_0_o, 36);
    alloc(1, 1, 1, 36, 37);

    // Random alloc/release against a FIFO model of the free tags.
    do_reset();
    freeq.delete();
    inuse.delete();
    for (int i = 32; i < 64; i++) freeq.push_back(i);
    repeat (200) begin
      av = ($urandom_range(0, 3) != 0);
      n0 = 1'($urandom_range(0, 1));
      n1 = 1'($urandom_range(0, 1));
      rr0 = 0; rr1 = 0;
      r0 = (inuse.size() > 0) && ($urandom_range(0, 2) != 0);
      if (r0) begin
        k = $urandom_range(0, inuse.size() - 1);
        rr0 = inuse[k];
        inuse.delete(k);
      end
      r1 = (inuse.size() > 0) && ($urandom_range(0, 2) != 0);
      if (r1) begin
        k = $urandom_range(0, inuse.size() - 1);
        rr1 = inuse[k];
        inuse.delete(k);
      end
      n   = int'(n0) + int'(n1);
      rdy = (freeq.size() >= n);
      e0  = (freeq.size() > 0) ? freeq[0] : 0;
      e1  = n0 ? ((freeq.size() > 1) ? freeq[1] : 0) : e0;
      cyc(av, n0, n1, r0, rr0, r1, rr1, 0, 0, rdy, e0, e1);
      if (av && rdy) repeat (n) inuse.push_back(freeq.pop_front());
      if (r0) freeq.push_back(rr0);
      if (r1) freeq.push_back(rr1);
    end

    // Reset in the middle of a run.
    do_reset();

    @(posedge clk); #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
